rr_arb16_sched: RTL
===================

# rr_arb16_sched

- Round-robin scheduler that shares one 4-to-16 active-low decoder among 16 requesters.
- Drives the decoder's enable (`en`) and 4-bit select (`w`), so the decoder's active-low line `y[w]` is the grant for requester `w`.
- Enforces a maximum grant length.
- Inserts one dead cycle (`en=0`, all decoder outputs high) between grants so two active-low lines never overlap.

## Interface

Parameters:
- `MAX_HOLD`, default 8: maximum number of consecutive cycles one grant is held. Legal range 1..255.

Ports:
- `clk`  input  1  — single clock; all state changes on the rising edge.
- `rst`  input  1  — reset, asynchronous and active-high.
- `req`  input  16  — request vector; `req[i]=1` means requester i wants the resource.
- `done`  input  1  — the current holder releases; sampled only in GRANT.
- `en`  output  1  — decoder enable, active-high. When `en=0`, all decoder outputs are high.
- `w`  output  4  — decoder select = index of the granted requester.
- `busy`  output  1  — high while in GRANT.
- `timeout`  output  1  — one-cycle pulse when a grant is revoked by the `MAX_HOLD` limit.

## Operation

- **State machine:** three states, IDLE, GRANT and GAP. All outputs are registered.
- **Round-robin pointer:** `ptr` is a 4-bit register, reset value 0.
- **Arbitration** runs in IDLE and GAP only:
  - Winner = first i with `req[i]=1`, searching `ptr, ptr+1, …, 15, 0, …, ptr-1` (mod 16).
- **IDLE:**
  - `en=0`, `busy=0`.
  - If `req != 0`: load `w` = winner, clear the hold counter, go to GRANT.
  - Otherwise stay in IDLE.
- **GRANT:**
  - `en=1`, `busy=1`. The hold counter increments every GRANT cycle, starting at 1 in the first GRANT cycle.
  - Release conditions, evaluated each edge: `done=1`, or `req[w]=0`, or hold counter == `MAX_HOLD`.
  - On release: go to GAP and set `ptr = w+1` (4-bit wrap, so 15 → 0).
  - `timeout=1` for the next cycle only if `MAX_HOLD` was the sole release reason. If `done` or a dropped `req` coincide with the limit, `timeout` stays 0.
  - `w` is frozen throughout GRANT. Changes to other `req` bits have no effect.
- **GAP:**
  - Exactly one cycle with `en=0`, `busy=0`.
  - Arbitrates using the updated `ptr`. On a winner it loads `w` and goes to GRANT; otherwise it goes to IDLE.
- **`w` outside GRANT:** keeps its last value in IDLE and GAP, except when GAP loads a new winner.
- **Hold counter:** width `$clog2(MAX_HOLD+1)`. It never exceeds `MAX_HOLD` and is cleared when GRANT is entered.
- **Reset values:** state IDLE, `en=0`, `w=0`, `busy=0`, `timeout=0`, `ptr=0`, hold counter 0.
- **Reset mid-grant:** `en` drops to 0 immediately and asynchronously; `ptr` returns to 0. No `timeout` pulse.
- **`MAX_HOLD=1`:** every grant lasts exactly one cycle; `timeout` pulses whenever neither `done` nor a dropped `req` caused the release.

## Timing

- **Grant latency from IDLE:** `req` high before edge N → `en=1` and `w` valid after edge N (1 cycle).
- **Grant length:** at most `MAX_HOLD` cycles of `en=1`.
  - `done` sampled high at the k-th GRANT edge ends the grant after k cycles of `en=1`.
- **Back-to-back grants:** after release there is exactly 1 GAP cycle with `en=0`; the next grant starts on the following edge. Minimum grant period = 2 cycles.
- **`timeout`:** asserted in the GAP cycle only; deasserted on the next edge.
- **Fairness:** a continuously requesting input is granted within 15 grants of any other requester.

## Test plan

- **Reset and idle:** assert `rst` asynchronously mid-cycle with `req=16'hFFFF` → `en=0`, `w=0`, `busy=0`, `timeout=0` immediately; after release with `req=0`, `en` stays 0 for 10 cycles.
- **Single request with `done`:** `req=16'h0020`, `done` raised at the 3rd GRANT cycle → `en=1`, `w=5` for exactly 3 cycles; GAP with `en=0`; grant re-issued to 5 with `ptr=6`.
- **Round robin with wrap-around:** `req=16'h8001` held, `done=1` every GRANT cycle → `w` sequence 0, 15, 0, 15 with one `en=0` cycle between each; `ptr` wraps 15 → 0.
- **Timeout:** `MAX_HOLD=4`, `req=16'h0008` held, `done=0` → `en=1`, `w=3` for 4 cycles; `timeout=1` in the GAP cycle only; regranted to 3.
- **Simultaneous release causes:** `MAX_HOLD=4`, `done=1` on the 4th GRANT cycle → release after 4 cycles with `timeout=0`.
- **Reset mid-grant:** `req=16'h0400` held, `rst` pulsed in the 2nd GRANT cycle → `en` falls without waiting for a clock edge; after reset is released, the grant returns to 10 after 1 cycle, with `ptr` search restarting from 0.

Source files
------------

// File: rtl/rr_arb16_sched.sv
// rr_arb16_sched: round-robin scheduler driving a shared 4-to-16 active-low decoder.
// Grants are bounded by MAX_HOLD cycles and separated by one dead (en=0) cycle.
`default_nettype none

module rr_arb16_sched #(
    parameter int MAX_HOLD = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] req,
    input  logic        done,
    output logic        en,
    output logic [3:0]  w,
    output logic        busy,
    output logic        timeout
);

    localparam int HW = $clog2(MAX_HOLD + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            en_q, en_d;
    logic            busy_q, busy_d;
    logic            timeout_q, timeout_d;
    logic [3:0]      w_q, w_d;
    logic [3:0]      ptr_q, ptr_d;
    logic [HW-1:0]   hold_q, hold_d;

    logic [31:0]     req_dbl;
    logic [15:0]     req_rot;
    logic [3:0]      win_off;
    logic            win_found;
    logic [3:0]      winner;
    logic [HW-1:0]   hold_inc;
    logic            at_limit;
    logic            req_held;

    // Rotate requests so the pointer position lands at bit 0; the lowest set
    // bit of the rotated vector is then the round-robin winner's offset.
    always_comb begin
        req_dbl   = {req, req} >> ptr_q;
        req_rot   = req_dbl[15:0];
        win_off   = 4'd0;
        win_found = 1'b0;
        for (int i = 15; i >= 0; i--) begin
            if (req_rot[i]) begin
                win_off   = 4'(i);
                win_found = 1'b1;
            end
        end
        winner = ptr_q + win_off;
    end

    // hold_q counts completed GRANT cycles, so hold_inc is the current cycle's count.
    assign hold_inc = hold_q + HW'(1);
    assign at_limit = (hold_inc == HW'(MAX_HOLD));
    assign req_held = req[w_q];

    always_comb begin
        state_d   = state_q;
        w_d       = w_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        timeout_d = 1'b0;
        case (state_q)
            S_IDLE, S_GAP: begin
                if (win_found) begin
                    w_d     = winner;
                    hold_d  = '0;
                    state_d = S_GRANT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_GRANT: begin
                hold_d = hold_inc;
                if (done || !req_held || at_limit) begin
                    state_d   = S_GAP;
                    ptr_d     = w_q + 4'd1;
                    timeout_d = at_limit && !done && req_held;
                end
            end
            default: state_d = S_IDLE;
        endcase
        en_d   = (state_d == S_GRANT);
        busy_d = (state_d == S_GRANT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            en_q      <= 1'b0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
            w_q       <= 4'd0;
            ptr_q     <= 4'd0;
            hold_q    <= '0;
        end else begin
            state_q   <= state_d;
            en_q      <= en_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
            w_q       <= w_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
        end
    end

    assign en      = en_q;
    assign w       = w_q;
    assign busy    = busy_q;
    assign timeout = timeout_q;

endmodule

`default_nettype wire
